// File: rtl/stopwatch_ctrl.sv
// Stop-watch front end: button conditioning, start/pause/clear FSM and tick prescaler.
// Define STOPWATCH_LAP_EN to add the lap button path and the lap_hold display-freeze flag.

module stopwatch_ctrl_btn #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic press
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic          sync_q1;
   logic          sync_q2;
   logic          deb_q;
   logic          deb_prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1    <= 1'b0;
         sync_q2    <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync_q1    <= raw;
         sync_q2    <= sync_q1;
         deb_prev_q <= deb_q;
         if (sync_q2 == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
            deb_q <= sync_q2;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_inc;
         end
      end
   end

   // Rising edge of the debounced level only; releases are ignored.
   assign press = deb_q & ~deb_prev_q;
endmodule

module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TICK_DIV        = 100
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_start_stop,
   input  logic btn_clear,
   input  logic btn_lap,
   output logic increment,
   output logic timer_clear,
   output logic running,
   output logic lap_hold
);
   localparam int unsigned PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic          inc_d;
   logic          clr_d;
   logic          ss_ev;
   logic          clr_ev;

   stopwatch_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_start_stop),
      .press   (ss_ev)
   );

   stopwatch_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_clear),
      .press   (clr_ev)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         increment   <= 1'b0;
         timer_clear <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         increment   <= inc_d;
         timer_clear <= clr_d;
      end
   end

   // Clear has priority: it drops a coincident start_stop event and any pending tick.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      inc_d   = 1'b0;
      clr_d   = 1'b0;
      if (clr_ev) begin
         state_d = IDLE;
         presc_d = '0;
         clr_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               presc_d = '0;
               if (ss_ev) state_d = RUN;
            end
            RUN: begin
               if (presc_q == PW'(TICK_DIV - 1)) begin
                  presc_d = '0;
                  inc_d   = 1'b1;
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               if (ss_ev) state_d = PAUSE;
            end
            PAUSE: begin
               if (ss_ev) state_d = RUN;
            end
            default: begin
               state_d = IDLE;
               presc_d = '0;
            end
         endcase
      end
   end

   assign running = (state_q == RUN);

`ifdef STOPWATCH_LAP_EN
   logic lap_ev;
   logic lap_q;
   logic lap_d;

   stopwatch_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_lap),
      .press   (lap_ev)
   );

   always_comb begin
      lap_d = lap_q;
      if (clr_ev) begin
         lap_d = 1'b0;
      end else if (lap_ev) begin
         case (state_q)
            RUN:     lap_d = ~lap_q;
            PAUSE:   lap_d = 1'b0;
            default: lap_d = lap_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lap_q <= 1'b0;
      else          lap_q <= lap_d;
   end

   assign lap_hold = lap_q;
`else
   logic lap_unused;
   assign lap_unused = btn_lap;
   assign lap_hold   = 1'b0;
`endif
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage for the stop-watch datapath. Synchronizes and debounces the raw push-buttons, runs the start/pause/clear state machine, and divides the system clock down to the single-cycle `increment` enable and `timer_clear` pulse. These two outputs drive the first counter of the cascaded timer chain. An optional lap feature adds a display-freeze flag for the downstream display stage.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button change is accepted; legal values ≥ 2.
- `TICK_DIV`, default 100: system clocks per `increment` pulse while running; legal values ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_start_stop`  in  1  raw, asynchronous, active-high button.
- `btn_clear`  in  1  raw, asynchronous, active-high button.
- `btn_lap`  in  1  raw, asynchronous, active-high button; used only with the lap feature.
- `increment`  out  1  one-cycle enable to the timer chain.
- `timer_clear`  out  1  one-cycle synchronous clear to the timer chain.
- `running`  out  1  high in state RUN.
- `lap_hold`  out  1  freeze request to the display stage.

## Operation
- **Reset.** While `reset_n` = 0 all outputs are 0, the state is IDLE, and all synchronizers, debounce counters and the prescaler are 0.
- **Per-button input path.**
  - The raw input passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: a counter of width `$clog2(DEBOUNCE_CYCLES)+1` counts consecutive cycles in which the synchronized value differs from the debounced value.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced value takes the synchronized value and the counter returns to 0. Any agreeing cycle also returns the counter to 0.
  - Press event: a one-cycle, combinational pulse = debounced & ~debounced_prev.
  - Releases generate no event.
- **State machine** (IDLE, RUN, PAUSE).
  - IDLE → RUN on a start_stop event.
  - RUN → PAUSE on a start_stop event.
  - PAUSE → RUN on a start_stop event.
  - A clear event in any state → IDLE, with `timer_clear` = 1 for exactly one cycle.
  - Clear and start_stop events in the same cycle: clear wins; the start_stop event is discarded, not queued.
- **Prescaler.**
  - Counter of width `$clog2(TICK_DIV)`.
  - In RUN it counts 0..`TICK_DIV`-1 and wraps.
  - `increment` = 1 (registered) in the cycle after the counter holds `TICK_DIV`-1. Period is therefore exactly `TICK_DIV` cycles.
  - In PAUSE it holds its value; resuming continues the partial period.
  - In IDLE, and on any clear, it is 0.
- **Exclusivity.** `increment` and `timer_clear` are never high in the same cycle; a clear suppresses a coincident tick.

## Timing
- A raw rise first sampled at edge N gives a debounced rise at edge N+1+`DEBOUNCE_CYCLES`. The press event is high for the following cycle. State and `running` change at edge N+2+`DEBOUNCE_CYCLES`.
- `timer_clear` is registered and is high for the cycle after the clear event.
- The first `increment` after IDLE→RUN is high `TICK_DIV` cycles after `running` rises.
- Bounces shorter than `DEBOUNCE_CYCLES` produce no event. A held button produces one event only.
- Reset asserted mid-count immediately forces all outputs to 0. The first event after release needs a full debounce window.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - `btn_lap` gets its own synchronizer and debouncer.
  - A lap event in RUN toggles `lap_hold`.
  - A lap event in PAUSE clears `lap_hold`.
  - A lap event in IDLE is ignored.
  - Any clear event clears `lap_hold`.
  - `lap_hold` is registered: it updates at the same edge as a state change.
- `STOPWATCH_LAP_EN` undefined: `btn_lap` is ignored with no logic behind it, and `lap_hold` is tied to 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TICK_DIV`=5.
1. **Start.** Release reset, then a clean start_stop press held 20 cycles → `running` rises 6 cycles after the first sampled high. `increment` pulses every 5 cycles, with the first pulse 5 cycles after `running`.
2. **Bounce.** Toggle start_stop every 2 cycles for 16 cycles, then hold low → no event, `running` stays 0, no `increment`.
3. **Pause.** Pause after 2 prescaler counts past a tick, hold 30 cycles, resume → no `increment` while paused. First `increment` after resume comes 3 cycles after `running` rises.
4. **Simultaneous press.** Press clear and start_stop together while in RUN → one `timer_clear` pulse, state IDLE, `running`=0, no `increment` afterward.
5. **Lap** (with `STOPWATCH_LAP_EN`). In RUN press lap → `lap_hold`=1 and `increment` continues. Press lap again → 0. Set `lap_hold`, then clear → `lap_hold`=0 together with the `timer_clear` pulse. Without the macro, `lap_hold` stays 0 throughout.
6. **Reset mid-run.** Assert `reset_n`=0 mid-period while running → all outputs are 0 within the same cycle. After release, state is IDLE.
